// File: rtl/display_arb_pkg.sv
// display_arb_pkg: shared types and constants for the display arbiter.
//   state_t      arbiter ownership states
//   NUM_DIGITS   number of seven-segment digits (HEX5..HEX0)
//   SEG_W        segments per digit
//   SEG_OFF      active-low pattern with every segment dark
//   hex_to_seg   0-F nibble to active-low seven-segment pattern
package display_arb_pkg;

    typedef enum logic [1:0] {
        HPS_IDLE,
        FAB_HOLD,
        HPS_HOLD
    } state_t;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned SEG_W      = 7;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_arbiter_hex7seg_decoder.sv
// hex7seg_decoder: combinational nibble to active-low seven-segment decoder.
//   nibble  in  4  hex digit
//   seg     out 7  active-low segments
module hex7seg_decoder
    import display_arb_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: shares HEX5..HEX0 and LEDR between the HPS PIO words and a
// fabric valid/ready snapshot port. The HPS owns the display by default; a
// fabric snapshot is held for HOLD_CYCLES, and owners alternate when both
// sides have pending requests.
//   clk_clk, reset_reset          clock, synchronous active-high reset
//   hps_hex30, hps_hex54, hps_leds HPS segment bytes (bit 7 ignored) and LEDs
//   fab_valid, fab_ready           fabric snapshot handshake
//   fab_value, fab_leds            six hex nibbles and LED pattern
//   hex_seg_n, ledr, owner         board outputs and current owner (1 = fabric)
// Optional: define DISP_ARB_ZERO_BLANK_EN to blank leading zero digits of the
// fabric snapshot (HEX0 is never blanked).
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] hps_hex30,
    input  logic [15:0] hps_hex54,
    input  logic [9:0]  hps_leds,
    input  logic        fab_valid,
    output logic        fab_ready,
    input  logic [23:0] fab_value,
    input  logic [9:0]  fab_leds,
    output logic [41:0] hex_seg_n,
    output logic [9:0]  ledr,
    output logic        owner
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [23:0] snap_val_q, snap_val_d;
    logic [9:0]  snap_leds_q, snap_leds_d;
    logic [57:0] prev_hps_q;
    logic [57:0] hps_word;
    logic        hps_chg;
    logic        ready_c;
    logic [47:0] hps_bytes;
    logic [41:0] hps_seg;
    logic [41:0] fab_seg_raw;
    logic [41:0] fab_seg;
    logic [41:0] hex_q;
    logic [9:0]  ledr_q;
    logic        owner_q;

    assign hps_word  = {hps_hex54, hps_hex30, hps_leds};
    assign hps_chg   = (hps_word != prev_hps_q);
    assign hps_bytes = {hps_hex54, hps_hex30};

    always_comb begin
        hps_seg = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            hps_seg[SEG_W*k +: SEG_W] = hps_bytes[8*k +: SEG_W];
        end
    end

    // Decode the snapshot that will be held after this edge, so the output
    // register shows it in the first cycle after the handshake.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        hex7seg_decoder u_dec (
            .nibble(snap_val_d[4*g +: 4]),
            .seg   (fab_seg_raw[SEG_W*g +: SEG_W])
        );
    end

`ifdef DISP_ARB_ZERO_BLANK_EN
    logic lead;
    always_comb begin
        fab_seg = fab_seg_raw;
        lead    = 1'b1;
        for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
            lead = lead & (snap_val_d[4*k +: 4] == 4'h0);
            if (lead) fab_seg[SEG_W*k +: SEG_W] = SEG_OFF;
        end
    end
`else
    assign fab_seg = fab_seg_raw;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        snap_val_d  = snap_val_q;
        snap_leds_d = snap_leds_q;
        ready_c     = 1'b0;
        case (state_q)
            HPS_IDLE: begin
                ready_c = 1'b1;
                if (fab_valid) begin
                    snap_val_d  = fab_value;
                    snap_leds_d = fab_leds;
                    cnt_d       = CNT_LOAD;
                    pend_d      = 1'b0;
                    state_d     = FAB_HOLD;
                end
            end
            FAB_HOLD: begin
                if (cnt_q == '0) begin
                    // ready uses the registered pend flag; a same-cycle HPS
                    // change still wins the expiry decision below
                    ready_c = ~pend_q;
                    if (pend_q || hps_chg) begin
                        cnt_d   = CNT_LOAD;
                        pend_d  = 1'b0;
                        state_d = HPS_HOLD;
                    end else if (fab_valid) begin
                        snap_val_d  = fab_value;
                        snap_leds_d = fab_leds;
                        cnt_d       = CNT_LOAD;
                    end else begin
                        state_d = HPS_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (hps_chg) pend_d = 1'b1;
                end
            end
            HPS_HOLD: begin
                if (cnt_q == '0) state_d = HPS_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = HPS_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q     <= HPS_IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            snap_val_q  <= '0;
            snap_leds_q <= '0;
            prev_hps_q  <= '0;
            hex_q       <= '1;
            ledr_q      <= '0;
            owner_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            snap_val_q  <= snap_val_d;
            snap_leds_q <= snap_leds_d;
            prev_hps_q  <= hps_word;
            if (state_d == FAB_HOLD) begin
                hex_q   <= fab_seg;
                ledr_q  <= snap_leds_d;
                owner_q <= 1'b1;
            end else begin
                hex_q   <= hps_seg;
                ledr_q  <= hps_leds;
                owner_q <= 1'b0;
            end
        end
    end

    assign fab_ready = ready_c & ~reset_reset;
    assign hex_seg_n = hex_q;
    assign ledr      = ledr_q;
    assign owner     = owner_q;

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Arbitrates the DE1-SoC HEX5..HEX0 seven-segment digits and LEDR[9:0] between two requesters:
  - the HPS, through the hex30/hex54/leds PIO words;
  - a fabric requester, such as annealer status, through a valid/ready snapshot port.
- The HPS owns the display by default. A fabric snapshot is shown for a guaranteed hold time, and the owners alternate when both have pending requests.
- Sits in the top level between the Qsys system exports and the board pins.

Parameters:
- HOLD_CYCLES, 50000000, minimum display time per granted hold in clk_clk cycles; must be at least 1.
- CNT_W, 26, width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- hps_hex30  in  32  segment patterns for HEX3..HEX0; byte k holds HEX k, bits [6:0] are active-low segments, bit 7 is ignored
- hps_hex54  in  16  segment patterns for HEX5..HEX4, same byte format
- hps_leds  in  10  LED pattern from the HPS
- fab_valid  in  1  fabric snapshot valid
- fab_ready  out  1  arbiter can accept a fabric snapshot
- fab_value  in  24  six hex nibbles; nibble k is shown on HEX k
- fab_leds  in  10  LED pattern accompanying the snapshot
- hex_seg_n  out  42  HEX k segments at [7k+6:7k], active-low
- ledr  out  10  LEDs
- owner  out  1  current display owner: 0 = HPS, 1 = fabric

Behaviour:
- Single clock domain, clk_clk. Reset is synchronous and active-high.
- Reset values: state HPS_IDLE; all of hex_seg_n = 1 (all segments dark); ledr = 0; owner = 0; counter = 0; hps_pend = 0; snapshot registers = 0; previous-HPS registers = 0.
- fab_ready is combinational from state and counter, and is forced to 0 while reset_reset = 1.
- HPS change detect: hps_chg = 1 when {hps_hex54, hps_hex30, hps_leds} differs from its value registered in the previous cycle.
- State HPS_IDLE:
  - Outputs follow the HPS words with 1-cycle register latency; owner = 0; fab_ready = 1.
  - When fab_valid & fab_ready: latch fab_value and fab_leds, load counter = HOLD_CYCLES-1, clear hps_pend, go to FAB_HOLD.
- State FAB_HOLD:
  - Outputs show the decoded snapshot from the cycle after the handshake; owner = 1.
  - Counter decrements each cycle. hps_chg sets hps_pend, which is sticky until cleared.
  - fab_ready = 1 only when counter == 0 and hps_pend == 0 (hps_pend sampled before any same-cycle hps_chg).
  - When counter == 0:
    - if hps_pend, or hps_chg in that same cycle: go to HPS_HOLD, load counter = HOLD_CYCLES-1, clear hps_pend;
    - else if fab_valid: latch the new snapshot, reload the counter, stay in FAB_HOLD (back-to-back holds);
    - else: go to HPS_IDLE.
- State HPS_HOLD:
  - Outputs follow the HPS words live; owner = 0; fab_ready = 0.
  - Counter decrements each cycle. At counter == 0, go to HPS_IDLE, which guarantees the HPS a full hold before the fabric can win again.
- Fabric decode: each nibble maps through the standard 0-F active-low seven-segment table. Examples: 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, F -> 7'h0E.
- HPS path: bits [6:0] of each byte pass through unmodified.
- HOLD_CYCLES = 1 gives a hold of exactly 1 cycle (counter loads 0 and expires on the next edge).
- fab_valid deasserting without a handshake is legal; nothing is latched.
- Reset mid-hold aborts the hold immediately and returns all outputs to their reset values on the next edge.

Optional Feature:
- Macro: DISP_ARB_ZERO_BLANK_EN.
- Defined: in fabric ownership, leading zero nibbles (from HEX5 downward, stopping at the first nonzero nibble) are blanked to 7'h7F. HEX0 is never blanked. Example: fab_value 24'h000A30 shows digits A30 only.
- Undefined: all six nibbles are always decoded.
- Has no effect on the HPS path.

Decomposition:
- Package display_arb_pkg:
  - state enum {HPS_IDLE, FAB_HOLD, HPS_HOLD};
  - NUM_DIGITS = 6;
  - SEG_W = 7;
  - SEG_OFF = 7'h7F;
  - hex-to-segment table as a constant function.
- Sub-module hex7seg_decoder: 4-bit nibble in, 7-bit active-low segments out, combinational.
- Instantiated 6 times inside display_arbiter.

Test Plan (HOLD_CYCLES = 4):
- Reset with all inputs 0, then release -> hex_seg_n all 1 during reset; first cycle after release shows HPS words (all 0, i.e. all segments lit); fab_ready = 1; owner = 0.
- hps_hex30 = 32'h79407940, idle -> next cycle hex_seg_n[27:0] = {7'h79, 7'h40, 7'h79, 7'h40}; owner = 0.
- fab_valid with fab_value = 24'h123456, fab_leds = 10'h155 -> next cycle shows digits 1,2,3,4,5,6 and ledr = 10'h155; owner = 1; fab_ready = 0 for 3 cycles, then back to HPS_IDLE if no further request.
- During FAB_HOLD, change hps_leds to 10'h3FF while fab_valid stays high -> on expiry owner = 0 for a 4-cycle HPS_HOLD with ledr = 10'h3FF; fab_ready reasserts only after that.
- fab_valid held high and HPS static -> back-to-back handshakes every 4 cycles; owner stays 1 and the new snapshot appears each hold.
- With DISP_ARB_ZERO_BLANK_EN and fab_value = 24'h000000 -> HEX5..HEX1 = 7'h7F, HEX0 = 7'h40. Assert reset_reset mid-hold -> all segments dark, owner = 0.
